// File: rtl/tree_loader_pkg.sv
// rtl/tree_loader_pkg.sv - shared types and constants for the tree image loader
package tree_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        NODE,
        WRITE,
        CHECK
    } loader_state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int NODE_BYTES = 7;

    // Only the two low bits of node byte 0 reach RAM1; the rest fall off the
    // top of the assembly register as bytes 1..5 shift in behind it.
    localparam int B0_KEEP_BITS = 2;

    // Assembly register holds node bytes 0..5; byte 6 is taken live from the
    // stream on the cycle the node completes.
    localparam int ASM_WIDTH = B0_KEEP_BITS + (NODE_BYTES - 2) * 8;

    // Big-endian slice positions inside the assembly register.
    localparam int RAM1_ASM_MSB = ASM_WIDTH - 1;   // b0[1:0]
    localparam int RAM1_ASM_LSB = 8;               // b4
    localparam int RAM2_ASM_MSB = 7;               // b5
    localparam int RAM2_ASM_LSB = 0;

endpackage

// File: rtl/tree_image_loader.sv
// rtl/tree_image_loader.sv - framed byte-stream writer for the decision-tree node RAMs
//
// Ports:
//   clk, rst            single clock; asynchronous active-low reset
//   s_data/s_valid      incoming image byte stream
//   s_ready             combinational: low only while a node write is held
//   ram_addr            shared write address for both node RAMs
//   ram1_data/ram2_data coefficient word and child-pointer word
//   we1/we2             write strobes, held WE_HOLD cycles per node
//   busy                frame in progress past the header
//   done                one-cycle pulse on a good checksum
//   error               sticky bad count / bad checksum, cleared by next header
module tree_image_loader
    import tree_loader_pkg::*;
#(
    parameter int ADDR_WIDTH      = 5,
    parameter int DEPTH           = 32,
    parameter int RAM1_DATA_WIDTH = 34,
    parameter int RAM2_DATA_WIDTH = 16,
    parameter int WE_HOLD         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [RAM1_DATA_WIDTH-1:0] ram1_data,
    output logic [RAM2_DATA_WIDTH-1:0] ram2_data,
    output logic                       we1,
    output logic                       we2,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int HOLD_W = (WE_HOLD > 1) ? $clog2(WE_HOLD) : 1;
    // One extra bit so a full-depth count (== 2^ADDR_WIDTH) fits.
    localparam int CNT_W  = ADDR_WIDTH + 1;

    loader_state_t         state;
    loader_state_t         state_next;

    logic [2:0]            byte_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [CNT_W-1:0]      remaining;
    logic [7:0]            xor_acc;
    logic [ASM_WIDTH-1:0]  asm_q;

    logic                  accept;
    logic                  count_bad;
    logic                  node_last;
    logic                  hold_last;
    logic                  last_node;

    assign accept    = s_valid && s_ready;
    assign count_bad = (s_data == 8'd0) || ({24'd0, s_data} > DEPTH);
    assign node_last = (byte_cnt == 3'(NODE_BYTES - 1));
    assign hold_last = (hold_cnt == HOLD_W'(WE_HOLD - 1));
    assign last_node = (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = (state != WRITE);
        case (state)
            IDLE: begin
                if (accept && s_data == HDR_BYTE) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (accept) begin
                    state_next = count_bad ? IDLE : NODE;
                end
            end
            NODE: begin
                if (accept && node_last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (hold_last) begin
                    state_next = last_node ? CHECK : NODE;
                end
            end
            CHECK: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr  <= '0;
            ram1_data <= '0;
            ram2_data <= '0;
            we1       <= 1'b0;
            we2       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            byte_cnt  <= '0;
            hold_cnt  <= '0;
            remaining <= '0;
            xor_acc   <= '0;
            asm_q     <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (accept && s_data == HDR_BYTE) begin
                        error <= 1'b0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (count_bad) begin
                            error <= 1'b1;
                        end else begin
                            remaining <= s_data[CNT_W-1:0];
                            ram_addr  <= '0;
                            xor_acc   <= s_data;
                            byte_cnt  <= '0;
                        end
                    end
                end
                NODE: begin
                    if (accept) begin
                        xor_acc <= xor_acc ^ s_data;
                        if (node_last) begin
                            ram1_data <= asm_q[RAM1_ASM_MSB:RAM1_ASM_LSB];
                            ram2_data <= {asm_q[RAM2_ASM_MSB:RAM2_ASM_LSB], s_data};
                            we1       <= 1'b1;
                            we2       <= 1'b1;
                            hold_cnt  <= '0;
                            byte_cnt  <= '0;
                        end else begin
                            asm_q    <= {asm_q[ASM_WIDTH-9:0], s_data};
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (hold_last) begin
                        we1       <= 1'b0;
                        we2       <= 1'b0;
                        remaining <= remaining - CNT_W'(1);
                        // Address stays on the last node so a full-depth
                        // frame never wraps back to 0.
                        if (!last_node) begin
                            ram_addr <= ram_addr + ADDR_WIDTH'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (s_data == xor_acc) begin
                            done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_image_loader.sv
// tb/tb_tree_image_loader.sv - self-checking bench for tree_image_loader
module tb_tree_image_loader;

    localparam int WE_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  ram_addr;
    logic [33:0] ram1_data;
    logic [15:0] ram2_data;
    logic        we1, we2, busy, done, error;

    tree_image_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .ram_addr  (ram_addr),
        .ram1_data (ram1_data),
        .ram2_data (ram2_data),
        .we1       (we1),
        .we2       (we2),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [4:0]  a;
        logic [33:0] d1;
        logic [15:0] d2;
    } wr_t;

    wr_t  wr_q[$];
    int   run_q[$];
    int   srun_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   unstable = 0;
    int   we_run = 0;
    int   s_run = 0;
    bit   we_prev = 0;
    bit   sr_prev = 1;
    int   hdr_cyc = 0;

    logic [7:0] pay[$];

    // Observes strobes, s_ready low stretches and done pulses away from the edge.
    always @(negedge clk) begin
        if (!rst) begin
            we_run = 0; s_run = 0; we_prev = 0; sr_prev = 1;
        end else begin
            if (we1 !== we2) unstable++;
            if (we1) begin
                if (!we_prev) begin
                    wr_t w;
                    w.a = ram_addr; w.d1 = ram1_data; w.d2 = ram2_data;
                    wr_q.push_back(w);
                    we_run = 1;
                end else begin
                    we_run++;
                    if (ram_addr !== wr_q[$].a || ram1_data !== wr_q[$].d1 ||
                        ram2_data !== wr_q[$].d2) unstable++;
                end
            end else if (we_prev) begin
                run_q.push_back(we_run);
            end
            we_prev = we1;
            if (!s_ready) begin
                s_run++;
            end else if (!sr_prev) begin
                srun_q.push_back(s_run);
                s_run = 0;
            end
            sr_prev = s_ready;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete(); run_q.delete(); srun_q.delete();
        done_cnt = 0; unstable = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sampled;
        int w;
        if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        w = 0;
        sampled = 0;
        while (w < 200) begin
            sampled = s_ready;
            @(posedge clk);
            #1;
            w++;
            if (sampled) break;
        end
        s_valid = 1'b0;
        total++;
        assert (sampled) else begin
            bad++;
            $error("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, w);
        end
    endtask

    // Reference: RAM words and checksum straight from the frame format.
    function automatic logic [33:0] m_r1(int i);
        logic [63:0] v;
        v = 64'(pay[7*i] & 8'h03) * 64'h1_0000_0000 + 64'(pay[7*i+1]) * 64'h100_0000 +
            64'(pay[7*i+2]) * 64'h1_0000 + 64'(pay[7*i+3]) * 64'h100 + 64'(pay[7*i+4]);
        return v[33:0];
    endfunction

    function automatic logic [15:0] m_r2(int i);
        return 16'(pay[7*i+5]) * 16'h100 + 16'(pay[7*i+6]);
    endfunction

    function automatic logic [7:0] m_csum(int n);
        logic [7:0] c;
        c = 8'(n);
        foreach (pay[k]) c = c ^ pay[k];
        return c;
    endfunction

    task automatic run_frame(input int n, input bit gaps, input logic [7:0] cflip);
        clear_mon();
        send_byte(8'hA5, gaps);
        hdr_cyc = cyc;
        send_byte(8'(n), gaps);
        for (int k = 0; k < 7 * n; k++) send_byte(pay[k], gaps);
        send_byte(m_csum(n) ^ cflip, gaps);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int n, input bit ok);
        chk("write_count", 64'(wr_q.size()), 64'(n));
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            chk("addr", 64'(wr_q[i].a), 64'(i));
            chk("ram1_data", 64'(wr_q[i].d1), 64'(m_r1(i)));
            chk("ram2_data", 64'(wr_q[i].d2), 64'(m_r2(i)));
        end
        chk("strobe_runs", 64'(run_q.size()), 64'(n));
        foreach (run_q[i]) chk("strobe_len", 64'(run_q[i]), 64'(WE_HOLD));
        chk("ready_low_runs", 64'(srun_q.size()), 64'(n));
        foreach (srun_q[i]) chk("ready_low_len", 64'(srun_q[i]), 64'(WE_HOLD));
        chk("strobe_stable", 64'(unstable), 64'd0);
        chk("done_count", 64'(done_cnt), ok ? 64'd1 : 64'd0);
        chk("error", 64'(error), ok ? 64'd0 : 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we1", 64'(we1), 64'd0);
        chk("rst_we2", 64'(we2), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram1", 64'(ram1_data), 64'd0);
        chk("rst_ram2", 64'(ram2_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Happy path with the documented two-node image.
        pay = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h81, 8'h05,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h84};
        run_frame(2, 0, 8'h00);
        check_frame(2, 1);
        if (wr_q.size() == 2) begin
            chk("happy_r1_0", 64'(wr_q[0].d1), 64'h3_0000_012C);
            chk("happy_r2_0", 64'(wr_q[0].d2), 64'h8105);
            chk("happy_r1_1", 64'(wr_q[1].d1), 64'h0_0000_000A);
            chk("happy_r2_1", 64'(wr_q[1].d2), 64'h0084);
        end
        chk("happy_latency", 64'(done_cyc - hdr_cyc), 64'(2 + 2 * (7 + WE_HOLD)));

        // Bad checksum: nodes still written, error sticky until next header.
        run_frame(2, 0, 8'h01);
        check_frame(2, 0);
        send_byte(8'h33, 0);
        chk("err_sticky", 64'(error), 64'd1);
        chk("err_idle_busy", 64'(busy), 64'd0);
        send_byte(8'hA5, 0);
        chk("err_cleared_by_hdr", 64'(error), 64'd0);
        chk("busy_in_count", 64'(busy), 64'd1);

        // Bad count 0 (continuing the header just sent).
        clear_mon();
        send_byte(8'h00, 0);
        @(posedge clk);
        #1;
        chk("cnt0_error", 64'(error), 64'd1);
        chk("cnt0_busy", 64'(busy), 64'd0);
        chk("cnt0_no_write", 64'(wr_q.size()), 64'd0);

        // Bad count 33, then a non-header byte is discarded.
        send_byte(8'hA5, 0);
        send_byte(8'h21, 0);
        @(posedge clk);
        #1;
        chk("cnt33_error", 64'(error), 64'd1);
        chk("cnt33_busy", 64'(busy), 64'd0);
        chk("cnt33_no_write", 64'(wr_q.size()), 64'd0);
        send_byte(8'h5A, 0);
        chk("discard_busy", 64'(busy), 64'd0);
        chk("discard_error", 64'(error), 64'd1);

        // Same happy image with random s_valid gaps.
        pay = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h81, 8'h05,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h84};
        run_frame(2, 1, 8'h00);
        check_frame(2, 1);

        // Random images with random gaps.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 6);
            pay.delete();
            for (int k = 0; k < 7 * n; k++) pay.push_back(8'($urandom));
            run_frame(n, 1, 8'h00);
            check_frame(n, 1);
        end

        // Reset during the second strobe cycle of node 1.
        pay = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h81, 8'h05,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h84};
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        for (int k = 0; k < 14; k++) send_byte(pay[k], 0);
        chk("strobe1_first_cycle", 64'(we1), 64'd1);
        @(posedge clk);
        #2;
        chk("strobe1_second_cycle", 64'(we1), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h55, 0);
        chk("post_rst_ignore", 64'(busy), 64'd0);
        run_frame(2, 0, 8'h00);
        check_frame(2, 1);

        // Full depth, distinct payload per node, no stalls.
        pay.delete();
        for (int i = 0; i < 32; i++) begin
            pay.push_back(8'(i));
            pay.push_back(8'(i) ^ 8'h5A);
            pay.push_back(8'($urandom));
            pay.push_back(8'($urandom));
            pay.push_back(8'(i));
            pay.push_back(8'(255 - i));
            pay.push_back(8'($urandom));
        end
        run_frame(32, 0, 8'h00);
        check_frame(32, 1);
        chk("full_latency", 64'(done_cyc - hdr_cyc), 64'(2 + 32 * (7 + WE_HOLD)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
